// File: rtl/reg_arb_pkg.sv
// rtl/reg_arb_pkg.sv - shared state encoding and width helper for register arbiters
package reg_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Number of bits needed to index n items; never returns less than 1
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic             any_o,
    output logic [PTR_W-1:0] winner_o
);

    logic [PTR_W-1:0] idx;

    // Scan from the far end back toward ptr so the closest request wins last
    always_comb begin
        any_o    = 1'b0;
        winner_o = '0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr_i) + k) % N);
            if (req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = idx;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter and sequencer for a shared register
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int DATA_W   = 8,
    parameter  int MAX_HOLD = 8,
    localparam int OW       = clog2_w(NUM_REQ),
    localparam int HW       = clog2_w(MAX_HOLD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [OW-1:0]             owner_id,
    output logic                      busy,
    output logic [DATA_W-1:0]         q,
    output logic                      q_valid
);

    arb_state_e          state_q, state_d;
    logic [OW-1:0]       ptr_q, ptr_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;

    logic                pick_any;
    logic [OW-1:0]       pick_winner;
    logic [HW-1:0]       hold_inc;
    logic [OW-1:0]       ptr_after_owner;
    logic [DATA_W-1:0]   lane [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (OW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

    assign hold_inc        = hold_q + 1'b1;
    assign ptr_after_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state: grant from IDLE, write or release from BUSY; release always passes through IDLE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        hold_d  = hold_q;
        data_d  = data_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d              = '0;
                    gnt_d[pick_winner] = 1'b1;
                    owner_d            = pick_winner;
                    hold_d             = '0;
                    state_d            = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (req[owner_q]) begin
                    data_d  = lane[owner_q];
                    valid_d = 1'b1;
                    hold_d  = hold_inc;
                    if (hold_inc == HW'(MAX_HOLD)) begin
                        gnt_d   = '0;
                        ptr_d   = ptr_after_owner;
                        state_d = ST_IDLE;
                    end
                end else begin
                    gnt_d   = '0;
                    ptr_d   = ptr_after_owner;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State and register bank; reset discards any grant or write of the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = (state_q == ST_BUSY);
    assign q        = data_q;
    assign q_valid  = valid_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - directed self-checking bench for reg_write_arbiter
module tb_reg_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic        busy;
    logic [7:0]  q;
    logic        q_valid;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (8),
        .MAX_HOLD (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .owner_id (owner_id),
        .busy     (busy),
        .q        (q),
        .q_valid  (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        wdata = 32'hC3A5_5A3C;

        // Reset with garbage inputs
        step();
        req   = 4'b1011;
        wdata = 32'h9966_7788;
        step();
        check("rst_q", q, 8'h00);
        check("rst_q_valid", q_valid, 1'b0);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner_id, 2'd0);
        rst = 1'b0;
        req = 4'b0000;
        step();
        check("idle_hold_gnt", gnt, 4'b0000);

        // Single requester
        req   = 4'b0001;
        wdata = 32'hDEAD_BEA5;
        step();
        check("single_gnt", gnt, 4'b0001);
        check("single_busy", busy, 1'b1);
        check("single_nowrite", q, 8'h00);
        step();
        check("single_q", q, 8'hA5);
        check("single_q_valid", q_valid, 1'b1);
        step();
        req = 4'b0000;
        step();
        check("single_rel_gnt", gnt, 4'b0000);
        check("single_rel_busy", busy, 1'b0);
        check("single_rel_q", q, 8'hA5);
        check("single_rel_owner", owner_id, 2'd0);

        // Round robin between 0 and 2, one write each
        do_reset();
        wdata = 32'hEE22_EE11;
        for (int r = 0; r < 2; r++) begin
            req = 4'b0101;
            step();
            check("rr_gnt0", gnt, 4'b0001);
            step();
            check("rr_q0", q, 8'h11);
            req = 4'b0100;
            step();
            check("rr_rel0", gnt, 4'b0000);
            req = 4'b0101;
            step();
            check("rr_gnt2", gnt, 4'b0100);
            check("rr_owner2", owner_id, 2'd2);
            step();
            check("rr_q2", q, 8'h22);
            req = 4'b0001;
            step();
            check("rr_rel2", gnt, 4'b0000);
        end

        // Hold limit with requester 3 pending
        do_reset();
        req   = 4'b1010;
        wdata = 32'hBB00_CC00;
        step();
        check("hold_gnt1", gnt, 4'b0010);
        for (int i = 1; i <= 4; i++) begin
            wdata[15:8] = 8'(8'h40 + i);
            step();
            check("hold_q", q, 8'(8'h40 + i));
            check("hold_gnt", gnt, (i < 4) ? 4'b0010 : 4'b0000);
        end
        check("hold_rel_busy", busy, 1'b0);
        step();
        check("hold_next_gnt", gnt, 4'b1000);
        check("hold_next_owner", owner_id, 2'd3);
        step();
        check("hold_q3", q, 8'hBB);
        req = 4'b0001;
        step();
        check("wrap_rel", gnt, 4'b0000);
        check("wrap_owner_kept", owner_id, 2'd3);
        step();
        check("wrap_gnt0", gnt, 4'b0001);

        // Non-owner isolation
        do_reset();
        req   = 4'b0101;
        wdata = 32'h77FF_883C;
        step();
        check("iso_gnt0", gnt, 4'b0001);
        step();
        check("iso_q_a", q, 8'h3C);
        step();
        check("iso_q_b", q, 8'h3C);
        req = 4'b0100;
        step();
        check("iso_rel_q", q, 8'h3C);
        step();
        check("iso_gnt2", gnt, 4'b0100);
        check("iso_grant_q", q, 8'h3C);
        step();
        check("iso_q2", q, 8'hFF);

        // Reset mid-burst while owner 2 is busy
        check("mid_busy_pre", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_gnt", gnt, 4'b0000);
        check("mid_q", q, 8'h00);
        check("mid_q_valid", q_valid, 1'b0);
        check("mid_busy", busy, 1'b0);
        check("mid_owner", owner_id, 2'd0);
        req = 4'b0110;
        step();
        check("mid_next_gnt", gnt, 4'b0010);
        check("mid_next_owner", owner_id, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
